// File: rtl/processor_onchip_memory_arbiter_pkg.sv
// Shared types for the on-chip RAM arbiter: FSM encoding, requester IDs and
// a small helper that classifies an Avalon access.
package processor_onchip_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic ID_RQ0 = 1'b0;
  localparam logic ID_RQ1 = 1'b1;

  // read and write together is a write, so only a pure read returns data
  function automatic logic is_read(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/processor_mem_arb_grant.sv
// Sticky-ownership grant FSM with a bounded hold. Grant is combinational from
// the current requests and the registered owner/hold state.
module processor_mem_arb_grant
  import processor_onchip_memory_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant,
  output logic       grant_id
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    grant   = 2'b00;
    state_d = state_q;
    hold_d  = hold_q;
    if (reset) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0) begin
            grant   = 2'b01;
            state_d = ST_OWN0;
            hold_d  = HOLD_ONE;
          end else if (req1) begin
            grant   = 2'b10;
            state_d = ST_OWN1;
            hold_d  = HOLD_ONE;
          end else begin
            hold_d  = '0;
          end
        end
        ST_OWN0: begin
          if (req0 && (hold_q < HOLD_MAX || !req1)) begin
            grant  = 2'b01;
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
          end else if (req1) begin
            grant   = 2'b10;
            state_d = ST_OWN1;
            hold_d  = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end
        ST_OWN1: begin
          if (req1 && (hold_q < HOLD_MAX || !req0)) begin
            grant  = 2'b10;
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
          end else if (req0) begin
            grant   = 2'b01;
            state_d = ST_OWN0;
            hold_d  = HOLD_ONE;
          end else begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign grant_id = grant[1] ? ID_RQ1 : ID_RQ0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/processor_onchip_memory_arbiter.sv
// Two-requester arbiter in front of the single-port on-chip RAM: muxes the
// granted Avalon request onto the RAM port and routes read data back.
module processor_onchip_memory_arbiter
  import processor_onchip_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int BE_W     = DATA_W / 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [BE_W-1:0]   rq0_byteenable,
  input  logic              rq0_read,
  input  logic              rq0_write,
  input  logic [DATA_W-1:0] rq0_writedata,
  output logic              rq0_waitrequest,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_readdatavalid,
  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [BE_W-1:0]   rq1_byteenable,
  input  logic              rq1_read,
  input  logic              rq1_write,
  input  logic [DATA_W-1:0] rq1_writedata,
  output logic              rq1_waitrequest,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] grant;
  logic       grant_id;
  logic       sel_read;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;
  logic       rd_vld;

  processor_mem_arb_grant #(
    .MAX_HOLD (MAX_HOLD)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .req0     (rq0_read | rq0_write),
    .req1     (rq1_read | rq1_write),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign rq0_waitrequest = reset | ~grant[0];
  assign rq1_waitrequest = reset | ~grant[1];
  assign mem_chipselect  = grant[0] | grant[1];
  assign mem_clken       = 1'b1;

  // idle port drives zeros so the RAM sees a quiet bus outside grants
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    sel_read       = 1'b0;
    if (grant[0]) begin
      mem_address    = rq0_address;
      mem_byteenable = rq0_byteenable;
      mem_write      = rq0_write;
      mem_writedata  = rq0_writedata;
      sel_read       = rq0_read;
    end else if (grant[1]) begin
      mem_address    = rq1_address;
      mem_byteenable = rq1_byteenable;
      mem_write      = rq1_write;
      mem_writedata  = rq1_writedata;
      sel_read       = rq1_read;
    end
  end

  always_comb begin
    rd_pend_d = mem_chipselect & is_read(sel_read, mem_write);
    rd_id_d   = grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= ID_RQ0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // a read accepted just before reset must not surface while reset is high
  assign rd_vld            = rd_pend_q & ~reset;
  assign rq0_readdatavalid = rd_vld & (rd_id_q == ID_RQ0);
  assign rq1_readdatavalid = rd_vld & (rd_id_q == ID_RQ1);
  assign rq0_readdata      = rq0_readdatavalid ? mem_readdata : '0;
  assign rq1_readdata      = rq1_readdatavalid ? mem_readdata : '0;

endmodule
